// File: rtl/sysu_mux_pkg.sv
// Shared constants and helpers for the scanning multi-channel selector.
package sysu_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // Ceiling log2 for sizing select and prescaler registers.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << bits) < value) begin
        bits = bits + 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/sysu_scan_counter.sv
// Select index register: loads the manual select or steps through 0..N-1
// under a DIV-clock prescaler in auto-scan mode.
module sysu_scan_counter
  import sysu_mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int DIV  = 4,
  localparam int SELW = clog2(N)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            MODE,
  input  logic            HOLD,
  input  logic [SELW-1:0] SEL,
  output logic [SELW-1:0] idx,
  output logic            STEP
);

  localparam int PW_RAW = clog2(DIV);
  localparam int PW     = (PW_RAW < 1) ? 1 : PW_RAW;

  localparam logic [PW-1:0]   P_MAX   = PW'(DIV - 1);
  localparam logic [SELW-1:0] IDX_MAX = SELW'(N - 1);
  localparam logic [SELW:0]   N_W     = (SELW + 1)'(N);

  logic [PW-1:0]   p_d, p_q;
  logic [SELW-1:0] idx_d, idx_q;
  logic            step_d, step_q;
  logic            sel_in_range;

  assign sel_in_range = ({1'b0, SEL} < N_W);

  // Next prescaler/index/step values for manual load, hold, or scan step.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch.
    p_d    = p_q;
    idx_d  = idx_q;
    step_d = 1'b0;
    if (MODE == MODE_MANUAL) begin
      p_d   = '0;
      idx_d = sel_in_range ? SEL : '0;
    end else if (!HOLD) begin
      if (p_q == P_MAX) begin
        p_d    = '0;
        idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + SELW'(1);
        step_d = 1'b1;
      end else begin
        p_d = p_q + PW'(1);
      end
    end
  end

  // State registers; asynchronous reset clears prescaler, index and pulse.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (RST) begin
      p_q    <= '0;
      idx_q  <= '0;
      step_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      idx_q  <= idx_d;
      step_q <= step_d;
    end
  end

  assign idx  = idx_q;
  assign STEP = step_q;

endmodule

// File: rtl/sysu_scan_mux.sv
// Registered CH-channel N:1 selector with manual or auto-scan select and
// per-channel active-low enables.
module sysu_scan_mux
  import sysu_mux_pkg::*;
#(
  parameter  int CH   = 2,
  parameter  int N    = 4,
  parameter  int W    = 4,
  parameter  int DIV  = 4,
  localparam int SELW = clog2(N)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                MODE,
  input  logic [SELW-1:0]     SEL,
  input  logic                HOLD,
  input  logic [CH-1:0]       E_n,
  input  logic [CH*N*W-1:0]   D,
  output logic [CH*W-1:0]     Y,
  output logic [SELW-1:0]     SEL_Q,
  output logic                STEP
);

  localparam logic [SELW:0] N_W = (SELW + 1)'(N);

  logic [SELW-1:0] idx;
  logic [SELW-1:0] sel_eff;
  logic            sel_ok;

  sysu_scan_counter #(
    .N   (N),
    .DIV (DIV)
  ) u_counter (
    .CLK  (CLK),
    .RST  (RST),
    .MODE (MODE),
    .HOLD (HOLD),
    .SEL  (SEL),
    .idx  (idx),
    .STEP (STEP)
  );

  // Manual mode selects straight from SEL; auto mode uses the stored index.
  assign sel_eff = (MODE == MODE_MANUAL) ? SEL : idx;
  assign sel_ok  = ({1'b0, sel_eff} < N_W);
  assign SEL_Q   = idx;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [W-1:0] d_ch [N];
    logic [W-1:0] y_d, y_q;

    for (genvar i = 0; i < N; i++) begin : g_in
      assign d_ch[i] = D[(c*N + i)*W +: W];
    end

    // Pick the selected input, forcing zero when disabled or out of range.
    always_comb begin
      y_d = '0;
      if (!E_n[c] && sel_ok) begin
        y_d = d_ch[sel_eff];
      end
    end

    // Output register for this channel.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        y_q <= '0;
      end else begin
        y_q <= y_d;
      end
    end

    assign Y[c*W +: W] = y_q;
  end

endmodule

// File: tb/tb_sysu_scan_mux.sv
// Scoreboard bench for sysu_scan_mux: two instances (N=4/DIV=4 and
// N=3/DIV=1) share control inputs; a reference model predicts each edge.
module tb_sysu_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        hold = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [1:0]  e_n = 2'b00;
  logic [31:0] d_a = '0;
  logic [23:0] d_b = '0;

  logic [7:0]  y_a, y_b;
  logic [1:0]  sel_q_a, sel_q_b;
  logic        step_a, step_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] y;
    logic [1:0] sel_q;
    logic       step;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   m_idx[2];
  int   m_p[2];

  always #5 clk = ~clk;

  sysu_scan_mux #(.CH(2), .N(4), .W(4), .DIV(4)) dut_a (
    .CLK(clk), .RST(rst), .MODE(mode), .SEL(sel), .HOLD(hold),
    .E_n(e_n), .D(d_a), .Y(y_a), .SEL_Q(sel_q_a), .STEP(step_a)
  );

  sysu_scan_mux #(.CH(2), .N(3), .W(4), .DIV(1)) dut_b (
    .CLK(clk), .RST(rst), .MODE(mode), .SEL(sel), .HOLD(hold),
    .E_n(e_n), .D(d_b), .Y(y_b), .SEL_Q(sel_q_b), .STEP(step_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the outputs become after one clock edge, given the
  // inputs seen at that edge, for a selector of n inputs and scan period div.
  function automatic exp_t model_edge(input int k, input int n, input int div, input logic [31:0] d);
    exp_t e;
    int   pick;
    pick = mode ? m_idx[k] : int'(sel);
    e.y  = '0;
    for (int c = 0; c < 2; c++) begin
      if (!e_n[c] && pick < n) begin
        e.y[c*4 +: 4] = 4'((d >> ((c*n + pick)*4)) & 32'hF);
      end
    end
    e.step = 1'b0;
    if (!mode) begin
      m_p[k]   = 0;
      m_idx[k] = (int'(sel) < n) ? int'(sel) : 0;
    end else if (!hold) begin
      m_p[k] = m_p[k] + 1;
      if (m_p[k] == div) begin
        m_p[k]   = 0;
        m_idx[k] = (m_idx[k] + 1) % n;
        e.step   = 1'b1;
      end
    end
    e.sel_q = 2'(m_idx[k]);
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.y = '0; e.sel_q = '0; e.step = 1'b0;
    return e;
  endfunction

  // Model process: pushes the expected outputs for every edge or reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idx = '{0, 0};
      m_p   = '{0, 0};
      q_a.delete();
      q_b.delete();
      q_a.push_back(reset_exp());
      q_b.push_back(reset_exp());
    end else begin
      q_a.push_back(model_edge(0, 4, 4, d_a));
      q_b.push_back(model_edge(1, 3, 1, {8'h00, d_b}));
    end
  end

  // Monitor: compares DUT outputs against queued expectations mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a_y", 32'(y_a), 32'(e.y));
      check("a_sel_q", 32'(sel_q_a), 32'(e.sel_q));
      check("a_step", 32'(step_a), 32'(e.step));
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b_y", 32'(y_b), 32'(e.y));
      check("b_sel_q", 32'(sel_q_b), 32'(e.sel_q));
      check("b_step", 32'(step_b), 32'(e.step));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int s;
    int steps;
    int found;

    // Reset state.
    tick(3);
    check("rst_y_a", 32'(y_a), 32'h0);
    check("rst_sel_q_a", 32'(sel_q_a), 32'h0);
    check("rst_step_a", 32'(step_a), 32'h0);
    rst = 1'b0;

    // Manual select, one-clock latency from SEL.
    sel = 2'd2;
    e_n = 2'b00;
    d_a = 32'h0A00_0500;
    tick(1);
    check("man_y", 32'(y_a), 32'hA5);
    check("man_sel_q", 32'(sel_q_a), 32'd2);
    check("man_step", 32'(step_a), 32'd0);

    // Manual -> auto: scan resumes from SEL=1, first step DIV clocks later.
    d_a = 32'h8765_4321;
    sel = 2'd1;
    tick(3);
    mode = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      if (i < 4) begin
        check("sw_sel_q_hold", 32'(sel_q_a), 32'd1);
        check("sw_no_step", 32'(step_a), 32'd0);
      end else begin
        check("sw_sel_q_step", 32'(sel_q_a), 32'd2);
        check("sw_step", 32'(step_a), 32'd1);
      end
    end

    // Scan with wrap: four steps in sixteen clocks.
    steps = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (step_a) steps++;
    end
    check("scan_step_count", 32'(steps), 32'd4);

    // Hold freezes the index and suppresses STEP.
    tick(2);
    hold = 1'b1;
    tick(1);
    s = int'(sel_q_a);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("hold_sel_q", 32'(sel_q_a), 32'(s));
      check("hold_step", 32'(step_a), 32'd0);
    end
    hold = 1'b0;
    e_n  = 2'b10;
    tick(1);
    check("en_ch1_zero", 32'(y_a[7:4]), 32'h0);

    // N=3, DIV=1: index advances every clock, STEP stays high.
    e_n = 2'b00;
    d_b = 24'h9AB_CDE;
    tick(1);
    s = int'(sel_q_b);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      s = (s + 1) % 3;
      check("b_step_high", 32'(step_b), 32'd1);
      check("b_sel_q_seq", 32'(sel_q_b), 32'(s));
    end
    mode = 1'b0;
    sel  = 2'd3;
    tick(1);
    check("b_oor_y", 32'(y_b), 32'h0);
    check("b_oor_sel_q", 32'(sel_q_b), 32'd0);

    // Asynchronous reset mid-scan, then first step four clocks after release.
    rst = 1'b1;
    tick(2);
    mode = 1'b1;
    hold = 1'b0;
    e_n  = 2'b00;
    rst  = 1'b0;
    tick(11);
    check("pre_rst_sel_q", 32'(sel_q_a), 32'd2);
    rst = 1'b1;
    #1;
    check("async_rst_y", 32'(y_a), 32'h0);
    check("async_rst_sel_q", 32'(sel_q_a), 32'h0);
    check("async_rst_step", 32'(step_a), 32'h0);
    tick(2);
    rst = 1'b0;
    found = -1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (step_a && found < 0) found = i;
    end
    check("post_rst_first_step", 32'(found), 32'd4);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      mode = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 4) == 0);
      sel  = 2'($urandom_range(0, 3));
      e_n  = 2'($urandom_range(0, 3));
      d_a  = $urandom;
      d_b  = 24'($urandom);
      tick(1);
    end

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
